// File: rtl/mem_bus_master.sv
//==============================================================================
//  Module      : mem_bus_master
//  Description : Initiator-side controller for the 1024x16 memory unit.
//                Accepts read/write/copy/fill commands over a valid/ready
//                handshake, sequences the memory cycles (combinational read,
//                write committed on the rising edge) and returns one
//                response pulse per command.
//                Optional macro MEM_BUS_PROTECT_EN: rejects any write, copy
//                or fill whose destination lies below CODE_LIMIT.
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_bus_master #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 16,
   parameter int MEM_DEPTH  = 1024,
   parameter int LEN_W      = 8,
   parameter int CODE_LIMIT = 200
) (
   input  logic              ClockInput,
   input  logic              ResetInputN,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic [1:0]        ReqOp,
   input  logic [ADDR_W-1:0] ReqAddress,
   input  logic [ADDR_W-1:0] ReqSource,
   input  logic [DATA_W-1:0] ReqData,
   input  logic [LEN_W-1:0]  ReqLength,
   output logic              RspValid,
   output logic [DATA_W-1:0] RspData,
   output logic              RspError,
   output logic              Busy,
   output logic [ADDR_W-1:0] AddressLine,
   output logic [DATA_W-1:0] MEMWriteBus,
   output logic              WriteMEM,
   input  logic [DATA_W-1:0] MEMReadBus
);

   // Range checks run at this width so address + length can never wrap.
   localparam int EXT_W = ADDR_W + LEN_W + 1;

   localparam logic [EXT_W-1:0]  c_depthExt = EXT_W'(MEM_DEPTH);
   localparam logic [EXT_W-1:0]  c_limitExt = EXT_W'(CODE_LIMIT);
   localparam logic [ADDR_W-1:0] c_addrOne  = ADDR_W'(1);
   localparam logic [LEN_W-1:0]  c_lenOne   = LEN_W'(1);

`ifdef MEM_BUS_PROTECT_EN
   localparam logic c_protectEn = 1'b1;
`else
   localparam logic c_protectEn = 1'b0;
`endif

   localparam logic [1:0] c_opRead  = 2'b00;
   localparam logic [1:0] c_opWrite = 2'b01;
   localparam logic [1:0] c_opCopy  = 2'b10;
   localparam logic [1:0] c_opFill  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_READ    = 3'd1,
      S_WRITE   = 3'd2,
      S_COPY_RD = 3'd3,
      S_COPY_WR = 3'd4,
      S_FILL    = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_ptrSrc;   // next copy source address
   logic [ADDR_W-1:0] r_ptrDst;   // next copy/fill destination address
   logic [LEN_W-1:0]  r_remain;   // words still to transfer after the current one
   logic              r_err;      // command was rejected at acceptance

   logic [EXT_W-1:0]  w_dstExt;
   logic [EXT_W-1:0]  w_srcExt;
   logic [EXT_W-1:0]  w_lenExt;
   logic [EXT_W-1:0]  w_dstEnd;
   logic [EXT_W-1:0]  w_srcEnd;
   logic              w_protViol;
   logic              w_legal;

   assign w_dstExt   = EXT_W'(ReqAddress);
   assign w_srcExt   = EXT_W'(ReqSource);
   assign w_lenExt   = EXT_W'(ReqLength);
   assign w_dstEnd   = w_dstExt + w_lenExt;
   assign w_srcEnd   = w_srcExt + w_lenExt;
   // Ranges are ascending from the destination base, so a non-empty range
   // touches the protected region exactly when its base does.
   assign w_protViol = c_protectEn && (w_dstExt < c_limitExt);

   // Legality of the command currently presented on the request port.
   always_comb begin
      w_legal = 1'b0;
      case (ReqOp)
         c_opRead:  w_legal = (w_dstExt < c_depthExt);
         c_opWrite: w_legal = (w_dstExt < c_depthExt) && !w_protViol;
         c_opCopy:  w_legal = (ReqLength != '0) && (w_srcEnd <= c_depthExt) &&
                              (w_dstEnd <= c_depthExt) && !w_protViol;
         default:   w_legal = (ReqLength != '0) && (w_dstEnd <= c_depthExt) &&
                              !w_protViol;
      endcase
   end

   // Command sequencer; every output is a register loaded on the edge that
   // enters the state it belongs to, so the memory port sees no Req* path.
   always_ff @(posedge ClockInput or negedge ResetInputN) begin
      if (!ResetInputN) begin
         r_state     <= S_IDLE;
         r_ptrSrc    <= '0;
         r_ptrDst    <= '0;
         r_remain    <= '0;
         r_err       <= 1'b0;
         ReqReady    <= 1'b1;
         Busy        <= 1'b0;
         RspValid    <= 1'b0;
         RspData     <= '0;
         RspError    <= 1'b0;
         AddressLine <= '0;
         MEMWriteBus <= '0;
         WriteMEM    <= 1'b0;
      end else begin
         RspValid <= 1'b0;
         WriteMEM <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (ReqValid) begin
                  ReqReady <= 1'b0;
                  Busy     <= 1'b1;
                  r_err    <= !w_legal;
                  if (!w_legal) begin
                     // A rejected command idles one silent cycle in READ so
                     // its response lands with the same latency as read/write.
                     r_state <= S_READ;
                  end else begin
                     case (ReqOp)
                        c_opRead: begin
                           r_state     <= S_READ;
                           AddressLine <= ReqAddress;
                        end
                        c_opWrite: begin
                           r_state     <= S_WRITE;
                           AddressLine <= ReqAddress;
                           MEMWriteBus <= ReqData;
                           WriteMEM    <= 1'b1;
                        end
                        c_opCopy: begin
                           r_state     <= S_COPY_RD;
                           AddressLine <= ReqSource;
                           r_ptrSrc    <= ReqSource + c_addrOne;
                           r_ptrDst    <= ReqAddress;
                           r_remain    <= ReqLength - c_lenOne;
                        end
                        default: begin
                           r_state     <= S_FILL;
                           AddressLine <= ReqAddress;
                           MEMWriteBus <= ReqData;
                           WriteMEM    <= 1'b1;
                           r_ptrDst    <= ReqAddress + c_addrOne;
                           r_remain    <= ReqLength - c_lenOne;
                        end
                     endcase
                  end
               end
            end
            S_READ: begin
               r_state     <= S_DONE;
               RspValid    <= 1'b1;
               RspError    <= r_err;
               RspData     <= r_err ? '0 : MEMReadBus;
               AddressLine <= '0;
            end
            S_WRITE: begin
               r_state     <= S_DONE;
               RspValid    <= 1'b1;
               RspError    <= 1'b0;
               RspData     <= MEMWriteBus;
               AddressLine <= '0;
               MEMWriteBus <= '0;
            end
            S_COPY_RD: begin
               // MEMWriteBus doubles as the holding register for the word read.
               r_state     <= S_COPY_WR;
               AddressLine <= r_ptrDst;
               MEMWriteBus <= MEMReadBus;
               WriteMEM    <= 1'b1;
               r_ptrDst    <= r_ptrDst + c_addrOne;
            end
            S_COPY_WR: begin
               if (r_remain == '0) begin
                  r_state     <= S_DONE;
                  RspValid    <= 1'b1;
                  RspError    <= 1'b0;
                  RspData     <= MEMWriteBus;
                  AddressLine <= '0;
                  MEMWriteBus <= '0;
               end else begin
                  r_state     <= S_COPY_RD;
                  AddressLine <= r_ptrSrc;
                  MEMWriteBus <= '0;
                  r_ptrSrc    <= r_ptrSrc + c_addrOne;
                  r_remain    <= r_remain - c_lenOne;
               end
            end
            S_FILL: begin
               if (r_remain == '0) begin
                  r_state     <= S_DONE;
                  RspValid    <= 1'b1;
                  RspError    <= 1'b0;
                  RspData     <= MEMWriteBus;
                  AddressLine <= '0;
                  MEMWriteBus <= '0;
               end else begin
                  AddressLine <= r_ptrDst;
                  WriteMEM    <= 1'b1;
                  r_ptrDst    <= r_ptrDst + c_addrOne;
                  r_remain    <= r_remain - c_lenOne;
               end
            end
            S_DONE: begin
               r_state  <= S_IDLE;
               ReqReady <= 1'b1;
               Busy     <= 1'b0;
               RspData  <= '0;
               RspError <= 1'b0;
               r_err    <= 1'b0;
            end
            default: begin
               r_state  <= S_IDLE;
               ReqReady <= 1'b1;
               Busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
Initiator-side controller that owns the memory port (AddressLine / MEMWriteBus / WriteMEM / MEMReadBus) of the 1024x16 memory unit.
- Accepts single-word read/write requests and multi-word copy/fill commands from a requester (datapath or debug loader) over a valid/ready handshake.
- Sequences the required memory cycles and returns one response pulse per command.
- The memory's read is combinational and its write commits on the rising clock edge; this block is built around exactly that timing.

Parameters:
- DATA_W, 16: memory word width.
- ADDR_W, 16: address width of request and memory port.
- MEM_DEPTH, 1024: number of valid words; any address >= MEM_DEPTH is illegal.
- LEN_W, 8: width of the copy/fill length field.
- CODE_LIMIT, 200: first writable address when MEM_BUS_PROTECT_EN is defined.

Ports:
- ClockInput  in  1  single clock; all state changes on its rising edge.
- ResetInputN  in  1  asynchronous, active-low reset.
- ReqValid  in  1  command present.
- ReqReady  out  1  block can accept a command.
- ReqOp  in  2  00 read, 01 write, 10 copy, 11 fill.
- ReqAddress  in  ADDR_W  read/write address; destination base for copy/fill.
- ReqSource  in  ADDR_W  source base for copy.
- ReqData  in  DATA_W  write data or fill value.
- ReqLength  in  LEN_W  word count for copy/fill; ignored for read/write.
- RspValid  out  1  one-cycle completion pulse.
- RspData  out  DATA_W  read data, or last word written for write/copy/fill.
- RspError  out  1  qualified by RspValid; command rejected.
- Busy  out  1  high in every state except IDLE.
- AddressLine  out  ADDR_W  memory address.
- MEMWriteBus  out  DATA_W  memory write data.
- WriteMEM  out  1  memory write enable.
- MEMReadBus  in  DATA_W  memory combinational read data.

Behaviour:
- Reset state: while ResetInputN=0, and immediately on assertion (asynchronous), state=IDLE and all outputs 0 except ReqReady=1.
- Memory-side outputs are decoded from registered state and pointers only; no combinational path from Req* inputs.
- States: IDLE, READ, WRITE, COPY_RD, COPY_WR, FILL, DONE.
- ReqReady = (state==IDLE). A command is accepted on the edge where ReqValid && ReqReady.
- In IDLE: AddressLine=0, MEMWriteBus=0, WriteMEM=0.
- Legality check at acceptance, evaluated at ADDR_W+LEN_W+1 bits so there is no wrap:
  - read/write: addr < MEM_DEPTH.
  - copy: len != 0, src+len <= MEM_DEPTH and dst+len <= MEM_DEPTH.
  - fill: len != 0 and dst+len <= MEM_DEPTH.
- Illegal command: next state DONE with RspError=1 and RspData=0. Zero memory cycles are issued and WriteMEM never asserts.
- READ (1 cycle): AddressLine=addr. MEMReadBus is captured at the closing edge. Then DONE.
- WRITE (1 cycle): AddressLine=addr, MEMWriteBus=data, WriteMEM=1. Then DONE.
- COPY, per word i = 0..len-1, ascending:
  - COPY_RD: AddressLine=src+i; MEMReadBus is captured into a holding register.
  - COPY_WR: AddressLine=dst+i, MEMWriteBus=holding register, WriteMEM=1.
  - Total 2*len cycles. Overlapping ranges are defined by this strict ascending read-then-write order; no overlap detection.
- FILL: one cycle per word; AddressLine=dst+i, MEMWriteBus=value, WriteMEM=1. Total len cycles.
- DONE (1 cycle): RspValid=1 with RspData/RspError valid. Next state IDLE. There is no response backpressure.
- Latency, counted from the accept edge: RspValid is high in cycle 2 for read/write/illegal, cycle 2*len+1 for copy, cycle len+1 for fill.
  - Minimum command-to-command spacing is 3 cycles.
- Reset mid-command: the command is abandoned. Words already written stay written; no further WriteMEM; no response.
- Inputs are sampled only at acceptance. Later changes to Req* do not affect a command in flight.

Optional Feature:
- Macro MEM_BUS_PROTECT_EN.
- Defined: any write, copy or fill touching an address < CODE_LIMIT is illegal and rejected at acceptance as above. Reads are unaffected.
- Undefined: only the MEM_DEPTH bound is enforced. All addresses are writable.

Test Plan:
1. Reset, preload mem[200]=10. Read 200 -> RspValid 2 cycles after accept, RspData=0x000A, RspError=0, WriteMEM never 1.
2. Write 0x1234 to 300, then read 300 -> WriteMEM high exactly 1 cycle with AddressLine=300; read returns 0x1234.
3. Preload mem[200]=10, mem[201]=11, mem[202]=0. Copy src=200, dst=400, len=3 -> mem[400..402]=10,11,0; RspValid 7 cycles after accept; RspData=0; exactly 3 WriteMEM pulses.
4. Fill 0xBEEF, dst=1020, len=4 -> mem[1020..1023]=0xBEEF, RspError=0. Fill dst=1020, len=5 -> RspError=1 at cycle 2, no WriteMEM. Copy with len=0 -> RspError=1.
5. Copy len=3 with ResetInputN pulled low mid-copy, after the 2nd WriteMEM -> outputs 0 asynchronously, no RspValid, 3rd destination word unchanged, ReqReady=1 after release.
6. MEM_BUS_PROTECT_EN defined: write 0xFFFF to addr 5 -> RspError=1, mem[5] unchanged; read 5 still succeeds. Undefined: same write succeeds.
